// File: rtl/gmr_stream.sv
// Massey-Rueppel keystream generator: a control LFSR M gates a data LFSR L,
// and the parity of the gated bits is packed into words behind a valid/ready port.
module gmr_stream #(
  parameter int unsigned        M_WIDTH = 7,
  parameter int unsigned        L_WIDTH = 13,
  parameter logic [M_WIDTH-1:0] M_TAPS  = 7'h60,
  parameter logic [L_WIDTH-1:0] L_TAPS  = 13'h100D,
  parameter int unsigned        SPEED   = 1,
  parameter int unsigned        WORD_W  = 8,
  parameter int unsigned        WARMUP  = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [M_WIDTH-1:0] i_seed_lfsrM,
  input  logic [L_WIDTH-1:0] i_seed_lfsrL,
  input  logic               i_enable,
  output logic [M_WIDTH-1:0] o_lfsrM,
  output logic [L_WIDTH-1:0] o_lfsrL,
  output logic [WORD_W-1:0]  o_ks_word,
  output logic               o_ks_valid,
  input  logic               i_ks_ready,
  output logic               o_seed_err
);

  localparam int unsigned CNT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned WARM_W = 8;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
  localparam logic [WARM_W-1:0] LAST_WARM = WARM_W'((WARMUP > 0) ? (WARMUP - 1) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } genStateT;

  genStateT            state;
  logic [CNT_W-1:0]    bitCnt;
  logic [WARM_W-1:0]   warmCnt;
  logic [WORD_W-1:0]   partial;

  logic                zBit;
  logic [M_WIDTH-1:0]  mStep;
  logic [L_WIDTH-1:0]  lStep;
  logic [WORD_W-1:0]   wordFull;
  logic                transfer;
  logic                lastBit;
  logic                stall;

  // Next LFSR states, the keystream bit from the current state, and handshake status
  always_comb begin
    zBit  = ^(o_lfsrM & o_lfsrL[M_WIDTH-1:0]);
    mStep = {o_lfsrM[M_WIDTH-2:0], ^(o_lfsrM & M_TAPS)};
    lStep = o_lfsrL;
    for (int unsigned i = 0; i < SPEED; i++) begin
      lStep = {lStep[L_WIDTH-2:0], ^(lStep & L_TAPS)};
    end
    wordFull         = partial;
    wordFull[bitCnt] = zBit;
    transfer         = o_ks_valid & i_ks_ready;
    lastBit          = (bitCnt == LAST_BIT);
    // A finished word may only overwrite the output slot if it is empty or draining now
    stall            = lastBit & o_ks_valid & ~i_ks_ready;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      bitCnt     <= '0;
      warmCnt    <= '0;
      partial    <= '0;
      o_lfsrM    <= '0;
      o_lfsrL    <= '0;
      o_ks_word  <= '0;
      o_ks_valid <= 1'b0;
      o_seed_err <= 1'b0;
    end else if (i_load) begin
      // All-zero seeds would lock the LFSRs, so they are forced to 1 and flagged
      o_lfsrM    <= (i_seed_lfsrM == '0) ? M_WIDTH'(1) : i_seed_lfsrM;
      o_lfsrL    <= (i_seed_lfsrL == '0) ? L_WIDTH'(1) : i_seed_lfsrL;
      o_seed_err <= (i_seed_lfsrM == '0) || (i_seed_lfsrL == '0);
      bitCnt     <= '0;
      warmCnt    <= '0;
      partial    <= '0;
      o_ks_valid <= 1'b0;
      state      <= (WARMUP == 0) ? RUN : WARM;
    end else begin
      if (transfer) begin
        o_ks_valid <= 1'b0;
      end
      case (state)
        WARM: begin
          if (i_enable) begin
            o_lfsrM <= mStep;
            o_lfsrL <= lStep;
            warmCnt <= warmCnt + WARM_W'(1);
            if (warmCnt == LAST_WARM) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (i_enable && !stall) begin
            o_lfsrM <= mStep;
            o_lfsrL <= lStep;
            if (lastBit) begin
              o_ks_word  <= wordFull;
              o_ks_valid <= 1'b1;
              bitCnt     <= '0;
            end else begin
              partial <= wordFull;
              bitCnt  <= bitCnt + CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmr_stream.sv
// Randomised/directed bench for gmr_stream: a bit-level keystream model predicts every
// accepted word, while directed phases cover latency, zero seeds, stalls, reload and reset.
module tb_gmr_stream;

  localparam int unsigned MW = 7;
  localparam int unsigned LW = 13;
  localparam logic [63:0] MT = 64'h60;
  localparam logic [63:0] LT = 64'h100D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          load0 = 1'b0, en0 = 1'b0, ready0 = 1'b0;
  logic [MW-1:0] seedM0 = '0;
  logic [LW-1:0] seedL0 = '0;
  logic [MW-1:0] lfsrM0;
  logic [LW-1:0] lfsrL0;
  logic [7:0]    word0;
  logic          valid0, err0;

  logic          load1 = 1'b0, en1 = 1'b0, ready1 = 1'b0;
  logic [MW-1:0] seedM1 = '0;
  logic [LW-1:0] seedL1 = '0;
  logic [MW-1:0] lfsrM1;
  logic [LW-1:0] lfsrL1;
  logic [15:0]   word1;
  logic          valid1, err1;

  gmr_stream u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load0),
    .i_seed_lfsrM(seedM0), .i_seed_lfsrL(seedL0), .i_enable(en0),
    .o_lfsrM(lfsrM0), .o_lfsrL(lfsrL0), .o_ks_word(word0),
    .o_ks_valid(valid0), .i_ks_ready(ready0), .o_seed_err(err0)
  );

  gmr_stream #(.SPEED(3), .WORD_W(16), .WARMUP(20)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load1),
    .i_seed_lfsrM(seedM1), .i_seed_lfsrL(seedL1), .i_enable(en1),
    .o_lfsrM(lfsrM1), .o_lfsrL(lfsrL1), .o_ks_word(word1),
    .o_ks_valid(valid1), .i_ks_ready(ready1), .o_seed_err(err1)
  );

  int nChk = 0;
  int nPass = 0;
  int words0 = 0;
  int words1 = 0;
  logic [63:0] exp0[$];
  logic [63:0] exp1[$];

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // n shifts of a Fibonacci LFSR of width w
  function automatic logic [63:0] stepN(input logic [63:0] s, input logic [63:0] taps,
                                        input int w, input int n);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < n; i++) s = ((s << 1) | 64'(^(s & taps))) & mask;
    return s;
  endfunction

  // Expected word stream from a load: zero-seed guard, warm-up discard, then packing
  task automatic genWords(input int dut, input logic [63:0] m, input logic [63:0] l,
                          input int speed, input int wordW, input int warm, input int n);
    logic [63:0] w;
    if (m == 0) m = 1;
    if (l == 0) l = 1;
    if (dut == 0) exp0.delete(); else exp1.delete();
    for (int i = 0; i < warm; i++) begin
      m = stepN(m, MT, MW, 1);
      l = stepN(l, LT, LW, speed);
    end
    for (int k = 0; k < n; k++) begin
      w = '0;
      for (int b = 0; b < wordW; b++) begin
        w[b] = ^(m & l);
        m = stepN(m, MT, MW, 1);
        l = stepN(l, LT, LW, speed);
      end
      if (dut == 0) exp0.push_back(w); else exp1.push_back(w);
    end
  endtask

  // Scoreboards: each accepted word must be the next model word
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && valid0 && ready0 && !load0) begin
      e = (exp0.size() > 0) ? exp0.pop_front() : '1;
      checkEq("u0 word", 64'(word0), e);
      words0++;
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n && valid1 && ready1 && !load1) begin
      e = (exp1.size() > 0) ? exp1.pop_front() : '1;
      checkEq("u1 word", 64'(word1), e);
      words1++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load0T(input logic [MW-1:0] m, input logic [LW-1:0] l);
    genWords(0, 64'(m), 64'(l), 1, 8, 0, 80);
    seedM0 = m;
    seedL0 = l;
    load0 = 1'b1;
    tick();
    load0 = 1'b0;
    seedM0 = MW'($urandom);
    seedL0 = LW'($urandom);
  endtask

  task automatic waitWords(input int dut, input int target, input int budget);
    int c;
    c = 0;
    while (((dut == 0) ? words0 : words1) < target && c < budget) begin
      tick();
      c++;
    end
    checkEq((dut == 0) ? "u0 word count" : "u1 word count",
            64'((dut == 0) ? words0 : words1), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ok;
    int w;
    logic [MW-1:0] rm;
    logic [LW-1:0] rl;

    // Reset state
    tick(); tick();
    checkEq("rst valid", 64'(valid0), 0);
    checkEq("rst word", 64'(word0), 0);
    checkEq("rst lfsrM", 64'(lfsrM0), 0);
    checkEq("rst lfsrL", 64'(lfsrL0), 0);
    checkEq("rst seed_err", 64'(err0), 0);
    rst_n = 1'b1;
    en0 = 1'b1;
    ready0 = 1'b1;
    tick(); tick(); tick();
    checkEq("idle no valid", 64'(valid0), 0);
    checkEq("idle no step", 64'(lfsrL0), 0);

    // Basic load, latency and 64-word stream
    load0T(7'h5A, 13'h15A7);
    checkEq("load lfsrM", 64'(lfsrM0), 64'h5A);
    checkEq("load lfsrL", 64'(lfsrL0), 64'h15A7);
    checkEq("load seed_err", 64'(err0), 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) checkEq("first step M", 64'(lfsrM0), stepN(64'h5A, MT, MW, 1));
      if (k == 7) checkEq("valid not early", 64'(valid0), 0);
    end
    checkEq("valid at 8", 64'(valid0), 1);
    checkEq("first bit", 64'(word0[0]), 1);
    waitWords(0, 64, 600);

    // Enable low freezes generation; the stream resumes without gaps in the model
    en0 = 1'b0;
    repeat (6) tick();
    checkEq("enable hold M", 64'(lfsrM0), stepN(64'h5A, MT, MW, 513));
    checkEq("enable hold L", 64'(lfsrL0), stepN(64'h15A7, LT, LW, 513));
    en0 = 1'b1;
    waitWords(0, 70, 80);

    // Zero seed guard
    load0T(7'h00, 13'h15A7);
    checkEq("zero seed M", 64'(lfsrM0), 64'h01);
    checkEq("zero seed err", 64'(err0), 1);
    waitWords(0, words0 + 3, 40);
    load0T(7'h5A, 13'h15A7);
    checkEq("seed err clear", 64'(err0), 0);

    // Backpressure: pending word held, LFSRs freeze when the second word is full
    ready0 = 1'b0;
    load0T(7'h5A, 13'h15A7);
    repeat (8) tick();
    checkEq("stall first valid", 64'(valid0), 1);
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!valid0 || 64'(word0) != exp0[0]) ok = 1'b0;
    end
    checkEq("stall word stable", 64'(ok), 1);
    checkEq("stall freeze M", 64'(lfsrM0), stepN(64'h5A, MT, MW, 15));
    checkEq("stall freeze L", 64'(lfsrL0), stepN(64'h15A7, LT, LW, 15));
    w = words0;
    ready0 = 1'b1;
    tick();
    checkEq("release refill valid", 64'(valid0), 1);
    tick();
    checkEq("back-to-back transfers", 64'(words0), 64'(w + 2));
    waitWords(0, w + 10, 100);

    // Reload mid-word with a pending word: pending word discarded
    ready0 = 1'b0;
    load0T(7'h5A, 13'h15A7);
    repeat (11) tick();
    load0T(7'h33, 13'h0ABC);
    checkEq("reload drops valid", 64'(valid0), 0);
    checkEq("reload lfsrM", 64'(lfsrM0), 64'h33);
    ready0 = 1'b1;
    waitWords(0, words0 + 8, 80);

    // Random seeds against the model
    for (int r = 0; r < 4; r++) begin
      rm = MW'($urandom);
      rl = LW'($urandom);
      load0T(rm, rl);
      waitWords(0, words0 + 6, 60);
    end

    // Asynchronous reset mid-run
    load0T(7'h11, 13'h0000);
    checkEq("zero L seed err", 64'(err0), 1);
    repeat (24) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkEq("async rst valid", 64'(valid0), 0);
    checkEq("async rst word", 64'(word0), 0);
    checkEq("async rst lfsrM", 64'(lfsrM0), 0);
    checkEq("async rst lfsrL", 64'(lfsrL0), 0);
    checkEq("async rst seed_err", 64'(err0), 0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    checkEq("post rst idle valid", 64'(valid0), 0);
    checkEq("post rst idle L", 64'(lfsrL0), 0);

    // SPEED=3, WORD_W=16, WARMUP=20 instance
    en1 = 1'b1;
    ready1 = 1'b1;
    genWords(1, 64'h5A, 64'h15A7, 3, 16, 20, 14);
    seedM1 = 7'h5A;
    seedL1 = 13'h15A7;
    load1 = 1'b1;
    tick();
    load1 = 1'b0;
    checkEq("u1 load L", 64'(lfsrL1), 64'h15A7);
    tick();
    checkEq("u1 L 3 steps", 64'(lfsrL1), stepN(64'h15A7, LT, LW, 3));
    checkEq("u1 M 1 step", 64'(lfsrM1), stepN(64'h5A, MT, MW, 1));
    for (int k = 2; k <= 36; k++) begin
      tick();
      if (k == 35) checkEq("u1 valid not early", 64'(valid1), 0);
    end
    checkEq("u1 valid at 36", 64'(valid1), 1);
    waitWords(1, 10, 200);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
